secure_receiver: RTL and testbench



---
 rtl/secure_pkg.sv | 19 +
 rtl/hamming74_decode.sv | 26 ++
 rtl/secure_receiver.sv | 107 ++++++++++
 tb/tb_secure_receiver.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/secure_pkg.sv
// Shared constants for the Hamming(7,4) receive path.
package secure_pkg;

    localparam int NPORTS = 4;
    localparam int CW_W   = 7;
    localparam int DW_W   = 6;

    // Codeword bit positions
    localparam int P0 = 0;
    localparam int P1 = 1;
    localparam int D0 = 2;
    localparam int P2 = 3;
    localparam int D1 = 4;
    localparam int D2 = 5;
    localparam int D3 = 6;

    typedef logic [CW_W-1:0] cw_t;

endpackage

// File: rtl/hamming74_decode.sv
// Combinational Hamming(7,4) single-error-correcting decoder.
module hamming74_decode
    import secure_pkg::*;
(
    input  logic [CW_W-1:0] cw,
    output logic [3:0]      data,
    output logic [2:0]      syndrome,
    output logic            corrected
);

    logic [CW_W-1:0] fixed;

    // Syndrome names the 1-based position of a single flipped bit; flip it back.
    always_comb begin
        syndrome[0] = cw[P0] ^ cw[D0] ^ cw[D1] ^ cw[D3];
        syndrome[1] = cw[P1] ^ cw[D0] ^ cw[D2] ^ cw[D3];
        syndrome[2] = cw[P2] ^ cw[D1] ^ cw[D2] ^ cw[D3];
        fixed = cw;
        for (int i = 0; i < CW_W; i++) begin
            if (syndrome == 3'(i + 1)) fixed[i] = ~cw[i];
        end
        data      = {fixed[D3], fixed[D2], fixed[D1], fixed[D0]};
        corrected = |syndrome;
    end

endmodule

// File: rtl/secure_receiver.sv
// Four-port Hamming(7,4) receiver: per-port one-entry buffers, round-robin
// merge, single-error correction and a saturating corrected-word counter.
module secure_receiver
    import secure_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CW_W-1:0]   cw_in0,
    input  logic [CW_W-1:0]   cw_in1,
    input  logic [CW_W-1:0]   cw_in2,
    input  logic [CW_W-1:0]   cw_in3,
    input  logic [NPORTS-1:0] cw_valid,
    output logic [NPORTS-1:0] cw_ready,
    output logic [DW_W-1:0]   d_out,
    output logic              d_valid,
    input  logic              d_ready,
    output logic              d_corrected,
    output logic [CNT_W-1:0]  corr_count
);

    cw_t               cw_in_arr [NPORTS];
    cw_t               cw_buf    [NPORTS];
    logic [NPORTS-1:0] full;
    logic [1:0]        rr_ptr;
    logic [1:0]        gnt_idx;
    logic              gnt_found;
    logic              gnt;
    cw_t               gnt_cw;
    logic [3:0]        dec_data;
    logic [2:0]        dec_syn;
    logic              dec_corr;

    assign cw_in_arr[0] = cw_in0;
    assign cw_in_arr[1] = cw_in1;
    assign cw_in_arr[2] = cw_in2;
    assign cw_in_arr[3] = cw_in3;
    assign cw_ready     = ~full;

    // Round-robin search from rr_ptr; grant only when the output slot frees up.
    always_comb begin
        gnt_idx   = rr_ptr;
        gnt_found = 1'b0;
        for (int k = 0; k < NPORTS; k++) begin
            if (!gnt_found && full[rr_ptr + 2'(k)]) begin
                gnt_found = 1'b1;
                gnt_idx   = rr_ptr + 2'(k);
            end
        end
        gnt    = gnt_found && (!d_valid || d_ready);
        gnt_cw = cw_buf[gnt_idx];
    end

    hamming74_decode u_dec (
        .cw        (gnt_cw),
        .data      (dec_data),
        .syndrome  (dec_syn),
        .corrected (dec_corr)
    );

    // Input buffers: a draining buffer does not capture in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= '0;
            for (int i = 0; i < NPORTS; i++) cw_buf[i] <= '0;
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                if (gnt && gnt_idx == 2'(i)) begin
                    full[i] <= 1'b0;
                end else if (cw_valid[i] && !full[i]) begin
                    full[i]   <= 1'b1;
                    cw_buf[i] <= cw_in_arr[i];
                end
            end
        end
    end

    // Priority moves to the port after the winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_ptr <= '0;
        else if (gnt) rr_ptr <= gnt_idx + 2'd1;
    end

    // Output register: reload on grant, hold under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_valid     <= 1'b0;
            d_out       <= '0;
            d_corrected <= 1'b0;
        end else if (gnt) begin
            d_valid     <= 1'b1;
            d_out       <= {gnt_idx, dec_data};
            d_corrected <= dec_corr;
        end else if (d_ready) begin
            d_valid     <= 1'b0;
        end
    end

    // Saturating count of corrected words loaded into the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) corr_count <= '0;
        else if (gnt && dec_corr && corr_count != {CNT_W{1'b1}})
            corr_count <= corr_count + 1'b1;
    end

endmodule

// File: tb/tb_secure_receiver.sv
// Self-checking bench for secure_receiver with a per-port expected-word scoreboard.
module tb_secure_receiver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] cw_in [4];
    logic [3:0] cw_valid;
    logic       d_ready;
    logic [3:0] cw_ready, d2_cw_ready;
    logic [5:0] d_out, d2_out;
    logic       d_valid, d2_valid, d_corrected, d2_corrected;
    logic [7:0] corr_count;
    logic [1:0] d2_count;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] pend_data [4];
    logic       pend_corr [4];
    logic [4:0] exp_q [4][$];
    logic [1:0] obs_ports [$];

    typedef struct {
        int         port;
        logic [6:0] cw;
        logic [3:0] data;
        logic       corr;
    } vec_t;
    vec_t tbl [12];

    always #5 clk = ~clk;

    secure_receiver #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .cw_in0(cw_in[0]), .cw_in1(cw_in[1]), .cw_in2(cw_in[2]), .cw_in3(cw_in[3]),
        .cw_valid(cw_valid), .cw_ready(cw_ready),
        .d_out(d_out), .d_valid(d_valid), .d_ready(d_ready),
        .d_corrected(d_corrected), .corr_count(corr_count)
    );

    secure_receiver #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .cw_in0(cw_in[0]), .cw_in1(cw_in[1]), .cw_in2(cw_in[2]), .cw_in3(cw_in[3]),
        .cw_valid(cw_valid), .cw_ready(d2_cw_ready),
        .d_out(d2_out), .d_valid(d2_valid), .d_ready(d_ready),
        .d_corrected(d2_corrected), .corr_count(d2_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] c;
        c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[3] = d[1] ^ d[2] ^ d[3];
        return c;
    endfunction

    // Scoreboard: push on input handshake, pop and compare on output handshake.
    always @(negedge clk) begin : mon
        logic [1:0] p;
        logic [4:0] e;
        if (!rst) begin
            for (int i = 0; i < 4; i++)
                if (cw_valid[i] && cw_ready[i]) exp_q[i].push_back({pend_corr[i], pend_data[i]});
            if (d_valid && d_ready) begin
                p = d_out[5:4];
                obs_ports.push_back(p);
                if (exp_q[p].size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL out_unexpected: got %h expected no word from port %0d", d_out, p);
                end else begin
                    e = exp_q[p].pop_front();
                    chk("out_data", 32'(d_out[3:0]), 32'(e[3:0]));
                    chk("out_corr", 32'(d_corrected), 32'(e[4]));
                end
            end
        end
    end

    task automatic clear_sb();
        for (int i = 0; i < 4; i++) exp_q[i].delete();
        obs_ports.delete();
    endtask

    task automatic do_reset();
        cw_valid = 4'h0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        clear_sb();
    endtask

    task automatic send(input int p, input logic [6:0] cw, input logic [3:0] data, input logic corr);
        bit done = 0;
        pend_data[p] = data;
        pend_corr[p] = corr;
        cw_in[p]     = cw;
        cw_valid[p]  = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (cw_ready[p]) done = 1;
            @(posedge clk);
            #1;
        end
        cw_valid[p] = 1'b0;
        chk("hs_timeout", 32'(done), 32'd1);
        @(negedge clk);
        chk("latency_early", 32'(d_valid), 32'd0);
        @(negedge clk);
        chk("latency_valid", 32'(d_valid), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (!d_valid && cw_ready == 4'hF && cw_valid == 4'h0) ok = 1;
        end
        chk("idle_timeout", 32'(ok), 32'd1);
        for (int i = 0; i < 4; i++) chk("lost_words", 32'(exp_q[i].size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] emask(input bit err, input int i, input int c);
        return err ? 7'(1 << ((i + c) % 7)) : 7'h00;
    endfunction

    task automatic stream_init(input bit err);
        for (int i = 0; i < 4; i++) begin
            pend_data[i] = 4'(4 * i + 1);
            pend_corr[i] = err;
            cw_in[i]     = enc(pend_data[i]) ^ emask(err, i, 0);
        end
        cw_valid = 4'hF;
    endtask

    // One cycle of continuous traffic: each port that handshook gets a fresh word.
    task automatic stream_step(input bit err, input int c);
        logic [3:0] hs;
        @(negedge clk);
        hs = cw_valid & cw_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) begin
                pend_data[i] = pend_data[i] + 4'd1;
                cw_in[i]     = enc(pend_data[i]) ^ emask(err, i, c + 1);
            end
        end
    endtask

    initial begin
        logic [5:0] held;
        cw_valid = 4'h0;
        d_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cw_in[i] = 7'h00; pend_data[i] = 4'h0; pend_corr[i] = 1'b0;
        end

        tbl[0]  = '{2, 7'h55, 4'hB, 1'b0};
        tbl[1]  = '{1, 7'h54, 4'hB, 1'b1};
        tbl[2]  = '{2, 7'h57, 4'hB, 1'b1};
        tbl[3]  = '{3, 7'h51, 4'hB, 1'b1};
        tbl[4]  = '{0, 7'h5D, 4'hB, 1'b1};
        tbl[5]  = '{2, 7'h45, 4'hB, 1'b1};
        tbl[6]  = '{2, 7'h75, 4'hB, 1'b1};
        tbl[7]  = '{3, 7'h15, 4'hB, 1'b1};
        tbl[8]  = '{0, 7'h00, 4'h0, 1'b0};
        tbl[9]  = '{1, 7'h7F, 4'hF, 1'b0};
        tbl[10] = '{3, 7'h33, 4'h6, 1'b0};
        tbl[11] = '{3, 7'h73, 4'h6, 1'b1};

        // Reset values
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", 32'(d_valid), 32'd0);
        chk("rst_dout", 32'(d_out), 32'd0);
        chk("rst_corr", 32'(d_corrected), 32'd0);
        chk("rst_count", 32'(corr_count), 32'd0);
        chk("rst_ready", 32'(cw_ready), 32'hF);
        @(posedge clk);
        #1 rst = 1'b0;

        // Table: clean words, every single-bit error position, zero and all-ones words
        for (int v = 0; v < 12; v++) begin
            send(tbl[v].port, tbl[v].cw, tbl[v].data, tbl[v].corr);
            if (v == 0) chk("clean_count", 32'(corr_count), 32'd0);
        end
        wait_idle();
        chk("table_count", 32'(corr_count), 32'd8);
        chk("table_sat_count", 32'(d2_count), 32'd3);

        // Saturation of the narrow counter
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            send(k % 4, 7'h15, 4'hB, 1'b1);
            chk("sat_count", 32'(d2_count), (k < 3) ? 32'(k) : 32'd3);
            chk("wide_count", 32'(corr_count), 32'(k));
        end
        wait_idle();

        // Round-robin fairness with all ports streaming
        do_reset();
        stream_init(1'b0);
        for (int c = 0; c < 20; c++) stream_step(1'b0, c);
        cw_valid = 4'h0;
        wait_idle();
        chk("rr_count", 32'(obs_ports.size() >= 16), 32'd1);
        for (int k = 0; k < 16; k++)
            if (k < obs_ports.size()) chk("rr_order", 32'(obs_ports[k]), 32'(k % 4));

        // Backpressure: output held, all buffers fill, nothing lost on release
        do_reset();
        d_ready = 1'b0;
        stream_init(1'b1);
        held = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 2) held = d_out;
            if (c >= 3) begin
                chk("bp_hold", 32'(d_out), 32'(held));
                chk("bp_ready", 32'(cw_ready), 32'h0);
                chk("bp_valid", 32'(d_valid), 32'd1);
            end
            @(posedge clk);
            #1;
        end
        cw_valid = 4'h0;
        d_ready  = 1'b1;
        wait_idle();
        chk("bp_count", 32'(corr_count), 32'd5);

        // Async reset in the middle of a stream
        do_reset();
        stream_init(1'b1);
        for (int c = 0; c < 6; c++) stream_step(1'b1, c);
        d_ready = 1'b0;
        for (int c = 6; c < 8; c++) stream_step(1'b1, c);
        chk("pre_valid", 32'(d_valid), 32'd1);
        chk("pre_count_nz", 32'(corr_count != 8'd0), 32'd1);
        #3;
        cw_valid = 4'h0;
        rst = 1'b1;
        #1;
        chk("async_valid", 32'(d_valid), 32'd0);
        chk("async_count", 32'(corr_count), 32'd0);
        chk("async_ready", 32'(cw_ready), 32'hF);
        chk("async_dout", 32'(d_out), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_sb();
        d_ready = 1'b1;
        send(1, 7'h33, 4'h6, 1'b0);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
